signed_add_arbiter: RTL and testbench
=====================================

SIGNED_ADD_ARBITER -- requirements
Module: signed_add_arbiter

Interface
REQ-001 Parameter CNT_W, default 8: width of each per-requester completed-operation counter.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0 / req1  input  1  request from requester 0 / 1; held high until acknowledged.
REQ-005 a0, b0 / a1, b1  input  16 each  operands of requester 0 / 1, sign-magnitude: bit 15 sign, bits 14:0 magnitude; stable while the matching req is high.
REQ-006 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-007 res  output  16  sign-magnitude sum; valid only in a cycle where ack0 or ack1 is high.
REQ-008 ovf  output  1  magnitude overflow of the acknowledged operation; valid with ack.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 cnt0 / cnt1  output  CNT_W each  completed operations per requester.

Function
REQ-011 FSM states SHALL be IDLE, EXEC and RESP; one adder instance is shared by both requesters.
REQ-012 IDLE: if any req is high, select a winner, latch its a/b into operand registers, record its id, and go to EXEC; otherwise stay in IDLE.
REQ-013 Arbitration SHALL be round-robin. The requester not served last wins when both request; a lone requester always wins. The last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-014 EXEC: the shared adder evaluates the latched operands; res and ovf are registered at the end of the cycle; go to RESP.
REQ-015 RESP: assert ack of the recorded id for exactly one cycle, increment that cnt (wrapping at 2^CNT_W), update the last-served pointer, and go to IDLE.
REQ-016 Latency SHALL be 3 cycles from the IDLE cycle sampling req to the ack pulse; throughput is one operation per 3 cycles.
REQ-017 Requesters SHALL drop req in the cycle after ack. A req still high in the next IDLE cycle is treated as a new request.
REQ-018 req and operand changes are ignored outside IDLE.
REQ-019 Same-sign addition: magnitude = (|a|+|b|) mod 2^15, sign = sign of a, ovf = carry out of bit 14.
REQ-020 Differing-sign addition: magnitude = larger minus smaller, sign = sign of the larger magnitude, ovf = 0.
REQ-021 Equal magnitudes with differing signs SHALL give res = 16'h0000.
REQ-022 A zero result SHALL always carry sign 0; negative zero is never produced.
REQ-023 Input operand -0 (16'h8000) SHALL be treated as +0.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle.
REQ-025 res and ovf SHALL hold their last values between acks.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE; ack0=ack1=0; busy=0; res=0; ovf=0; cnt0=cnt1=0; last-served pointer=1; operand registers=0.
REQ-027 Reset asserted during EXEC or RESP SHALL abort the operation with no ack and no cnt increment.
REQ-028 After reset release, arbitration SHALL start in the first clk edge with rst_n high.

Structure
REQ-029 A shared package SHALL hold: the FSM state encoding, SM_W=16, the sign-bit index 15, and the magnitude width 15.
REQ-030 One combinational sub-module, sm_add16, SHALL implement REQ-019 to REQ-023. It takes two 16-bit operands and returns a 16-bit result plus ovf, and is instantiated once.
REQ-031 Arbitration, the FSM, the operand/result registers and the counters SHALL live in signed_add_arbiter.

Verification
REQ-032 Single request: req0=1, a0=16'h0005, b0=16'h0003. Required: ack0 exactly 3 cycles later, res=16'h0008, ovf=0, cnt0=1, busy high for 2 cycles.
REQ-033 Tie and fairness: req0 and req1 rise together after reset, each held until its ack. Required: requester 0 served first, then requester 1; with both kept requesting, service strictly alternates 0,1,0,1; ack0 and ack1 never overlap.
REQ-034 Signed cases:
  - 16'h0005 + 16'h8007 gives res 16'h8002.
  - 16'h8009 + 16'h0009 gives res 16'h0000.
  - 16'h8004 + 16'h8004 gives res 16'h8008.
  - 16'h7FFF + 16'h0001 gives res 16'h0000, ovf=1.
REQ-035 Reset mid-operation: assert rst_n=0 during EXEC. Required: no ack, cnt unchanged at 0, all outputs at reset values, and a normal request completes after release.
REQ-036 Counter wrap: CNT_W=8, 256 requests from requester 1. Required: cnt1 returns to 0 and cnt0 stays 0.
REQ-037 Operand stability: change a0 during EXEC. Required: res reflects the operands latched in IDLE.

Source files
------------

// File: rtl/signed_add_arbiter_pkg.sv
// Shared types and widths for the signed-add arbiter and its adder.
package signed_add_arbiter_pkg;

   localparam int SM_W     = 16;
   localparam int SIGN_BIT = 15;
   localparam int MAG_W    = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/signed_add_arbiter_if.sv
// Requester-side bus of the signed-add arbiter: two request/operand
// channels in, acknowledge, result, status and counters out.
interface signed_add_arbiter_if #(
   parameter int CNT_W = 8
) ();
   import signed_add_arbiter_pkg::*;

   logic             req0;
   logic             req1;
   logic [SM_W-1:0]  a0;
   logic [SM_W-1:0]  b0;
   logic [SM_W-1:0]  a1;
   logic [SM_W-1:0]  b1;
   logic             ack0;
   logic             ack1;
   logic [SM_W-1:0]  res;
   logic             ovf;
   logic             busy;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   modport master (
      output req0, req1, a0, b0, a1, b1,
      input  ack0, ack1, res, ovf, busy, cnt0, cnt1
   );

   modport slave (
      input  req0, req1, a0, b0, a1, b1,
      output ack0, ack1, res, ovf, busy, cnt0, cnt1
   );

endinterface

// File: rtl/signed_add_arbiter_sm_add16.sv
// Combinational sign-magnitude adder. Negative zero on an input is read
// as +0, and a zero result always comes out with a positive sign.
module sm_add16
   import signed_add_arbiter_pkg::*;
(
   input  logic [SM_W-1:0] a,
   input  logic [SM_W-1:0] b,
   output logic [SM_W-1:0] sum,
   output logic            ovf
);

   logic [MAG_W-1:0] mag_a;
   logic [MAG_W-1:0] mag_b;
   logic             sgn_a;
   logic             sgn_b;
   logic [MAG_W:0]   total;
   logic [MAG_W-1:0] mag;
   logic             sgn;

   // Normalise signs, then add or subtract magnitudes depending on sign match.
   always_comb begin
      mag_a = a[MAG_W-1:0];
      mag_b = b[MAG_W-1:0];
      sgn_a = a[SIGN_BIT] & (|mag_a);
      sgn_b = b[SIGN_BIT] & (|mag_b);
      total = '0;
      mag   = '0;
      sgn   = 1'b0;
      ovf   = 1'b0;
      if (sgn_a == sgn_b) begin
         total = {1'b0, mag_a} + {1'b0, mag_b};
         mag   = total[MAG_W-1:0];
         ovf   = total[MAG_W];
         sgn   = sgn_a;
      end else if (mag_a >= mag_b) begin
         mag = mag_a - mag_b;
         sgn = sgn_a;
      end else begin
         mag = mag_b - mag_a;
         sgn = sgn_b;
      end
      sum = {sgn & (|mag), mag};
   end

endmodule

// File: rtl/signed_add_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude adder between two
// requesters. Each operation takes IDLE -> EXEC -> RESP.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | wait for a request; latch winner's operands and id
//   EXEC    | shared adder works on latched operands; result registered
//   RESP    | ack pulse to the served requester; count and move pointer
module signed_add_arbiter
   import signed_add_arbiter_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   signed_add_arbiter_if.slave bus
);

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             winner;
   logic             id;
   logic             last;
   logic [SM_W-1:0]  op_a;
   logic [SM_W-1:0]  op_b;
   logic [SM_W-1:0]  sum;
   logic             sum_ovf;
   logic [SM_W-1:0]  res_q;
   logic             ovf_q;
   logic             ack0_q;
   logic             ack1_q;
   logic [CNT_W-1:0] cnt0_q;
   logic [CNT_W-1:0] cnt1_q;

   sm_add16 u_add (
      .a   (op_a),
      .b   (op_b),
      .sum (sum),
      .ovf (sum_ovf)
   );

   // On a tie the requester not served last wins; a lone requester always wins.
   assign winner = (bus.req0 & bus.req1) ? ~last : bus.req1;

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.req0 | bus.req1) begin
               state_nxt = ST_EXEC;
               load      = 1'b1;
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, operand latch, result/ack registers, counters and pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         op_a   <= '0;
         op_b   <= '0;
         id     <= 1'b0;
         last   <= 1'b1;
         res_q  <= '0;
         ovf_q  <= 1'b0;
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         state  <= state_nxt;
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         if (load) begin
            op_a <= winner ? bus.a1 : bus.a0;
            op_b <= winner ? bus.b1 : bus.b0;
            id   <= winner;
         end
         // Ack is registered here so it is high exactly during RESP.
         if (state == ST_EXEC) begin
            res_q  <= sum;
            ovf_q  <= sum_ovf;
            ack0_q <= ~id;
            ack1_q <= id;
         end
         if (state == ST_RESP) begin
            last <= id;
            if (id) cnt1_q <= cnt1_q + 1'b1;
            else    cnt0_q <= cnt0_q + 1'b1;
         end
      end
   end

   assign bus.ack0 = ack0_q;
   assign bus.ack1 = ack1_q;
   assign bus.res  = res_q;
   assign bus.ovf  = ovf_q;
   assign bus.busy = (state != ST_IDLE);
   assign bus.cnt0 = cnt0_q;
   assign bus.cnt1 = cnt1_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Directed bench for signed_add_arbiter. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_signed_add_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [7:0] exp_cnt0;
   logic [7:0] exp_cnt1;

   signed_add_arbiter_if #(.CNT_W(8)) bus ();

   signed_add_arbiter #(.CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      exp_cnt0 = '0;
      exp_cnt1 = '0;
   endtask

   // One request from requester `rid`, started at a falling edge in IDLE.
   // Ack is expected on the second falling edge, i.e. in the RESP cycle,
   // the third cycle counting the IDLE cycle that samples the request.
   task automatic do_op(input bit rid, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic exp_ovf, input bit perturb);
      int  n;
      int  busy_cycles;
      bit  got;
      n = 0;
      busy_cycles = 0;
      got = 1'b0;
      if (rid) begin
         bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
      end else begin
         bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
      end
      while (!got && n < 8) begin
         @(negedge clk);
         n++;
         if (bus.busy) busy_cycles++;
         if (perturb && n == 1) begin
            if (rid) bus.a1 = a ^ 16'h00F0;
            else     bus.a0 = a ^ 16'h00F0;
         end
         if (rid ? bus.ack1 : bus.ack0) got = 1'b1;
      end
      check("ack_latency", n, 2);
      check("res", bus.res, exp_res);
      check("ovf", bus.ovf, exp_ovf);
      check("other_ack_low", rid ? bus.ack0 : bus.ack1, 1'b0);
      check("busy_cycles", busy_cycles, 2);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      if (rid) exp_cnt1 = exp_cnt1 + 8'd1;
      else     exp_cnt0 = exp_cnt0 + 8'd1;
      @(negedge clk);
      check("ack_one_cycle", rid ? bus.ack1 : bus.ack0, 1'b0);
      check("busy_idle", bus.busy, 1'b0);
      check("cnt0", bus.cnt0, exp_cnt0);
      check("cnt1", bus.cnt1, exp_cnt1);
      check("res_hold", bus.res, exp_res);
   endtask

   initial begin
      logic       exp_id [4];
      logic       seen_id [4];
      int         nacks;
      bit         ack_seen;

      checks   = 0;
      errors   = 0;
      exp_cnt0 = '0;
      exp_cnt1 = '0;
      rst_n    = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.a0   = '0;
      bus.b0   = '0;
      bus.a1   = '0;
      bus.b1   = '0;

      // Reset values.
      @(negedge clk);
      @(negedge clk);
      check("rst_ack0", bus.ack0, 1'b0);
      check("rst_ack1", bus.ack1, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_res", bus.res, 16'h0000);
      check("rst_ovf", bus.ovf, 1'b0);
      check("rst_cnt0", bus.cnt0, 8'd0);
      check("rst_cnt1", bus.cnt1, 8'd0);
      rst_n = 1'b1;

      // Single request, then signed cases alternating requesters.
      do_op(1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0);
      do_op(1'b0, 16'h0005, 16'h8007, 16'h8002, 1'b0, 1'b0);
      do_op(1'b1, 16'h8009, 16'h0009, 16'h0000, 1'b0, 1'b0);
      do_op(1'b0, 16'h8004, 16'h8004, 16'h8008, 1'b0, 1'b0);
      do_op(1'b1, 16'h7FFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
      do_op(1'b1, 16'h8000, 16'h8003, 16'h8003, 1'b0, 1'b0);
      do_op(1'b0, 16'h4000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      do_op(1'b1, 16'h0002, 16'h800A, 16'h8008, 1'b0, 1'b0);
      // Operand change during EXEC must not affect the result.
      do_op(1'b0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b1);

      // Tie and fairness: both held high, service must alternate 0,1,0,1.
      do_reset();
      exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
      seen_id[0] = 1'b1; seen_id[1] = 1'b1; seen_id[2] = 1'b1; seen_id[3] = 1'b1;
      nacks = 0;
      bus.a0 = 16'h0001; bus.b0 = 16'h0001;
      bus.a1 = 16'h0003; bus.b1 = 16'h0004;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         check("no_ack_overlap", bus.ack0 & bus.ack1, 1'b0);
         if (bus.ack0 || bus.ack1) begin
            if (nacks < 4) seen_id[nacks] = bus.ack1;
            check("tie_res", bus.res, bus.ack1 ? 16'h0007 : 16'h0002);
            nacks++;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      check("tie_nacks", nacks, 4);
      for (int i = 0; i < 4; i++) check("tie_order", seen_id[i], exp_id[i]);
      @(negedge clk);
      check("tie_cnt0", bus.cnt0, 8'd2);
      check("tie_cnt1", bus.cnt1, 8'd2);

      // Reset during EXEC aborts the operation.
      do_reset();
      bus.a0 = 16'h0005; bus.b0 = 16'h0003; bus.req0 = 1'b1;
      @(negedge clk);
      check("abort_in_exec", bus.busy, 1'b1);
      rst_n    = 1'b0;
      bus.req0 = 1'b0;
      #1;
      check("abort_ack0", bus.ack0, 1'b0);
      check("abort_ack1", bus.ack1, 1'b0);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_res", bus.res, 16'h0000);
      check("abort_ovf", bus.ovf, 1'b0);
      check("abort_cnt0", bus.cnt0, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ack_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.ack0 || bus.ack1) ack_seen = 1'b1;
      end
      check("abort_no_ack", ack_seen, 1'b0);
      check("abort_cnt0_after", bus.cnt0, 8'd0);
      do_op(1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0);

      // Counter wrap on requester 1.
      do_reset();
      for (int i = 0; i < 256; i++) do_op(1'b1, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);
      check("wrap_cnt1", bus.cnt1, 8'd0);
      check("wrap_cnt0", bus.cnt0, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
